// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//
// ID/EX pipeline register and operand-select stage in front of the 16-bit ALU.
// It captures the decoded instruction from ID, resolves read-after-write
// hazards by forwarding from the EX/MEM and MEM/WB latches, and detects
// load-use hazards. On a load-use hazard it stalls ID and inserts one bubble
// into EX. A downstream hold freezes the stage, and a branch flush squashes
// the instruction entering EX.
//
// Ports
//   clk, rst_n                  core clock, asynchronous active-low reset
//   id_*                        decoded instruction presented by ID
//   mem_rd/mem_reg_we/mem_result  EX/MEM forwarding source
//   wb_rd/wb_reg_we/wb_data       MEM/WB forwarding source
//   ex_hold                     downstream stall, freezes the EX registers
//   ex_flush                    squash the instruction entering EX
//   id_stall                    freeze PC and IF/ID
//   ex_valid                    EX holds a valid instruction
//   ex_a, ex_b, ex_store_data   forwarded ALU operands and store data
//   ex_alu_ctrl, ex_rd          registered ALU op and destination register
//   ex_reg_we, ex_is_load       registered flags, forced low when !ex_valid
//   stall_cnt                   saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module ex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_use,
    input  logic              id_rs2_use,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [CTRL_W-1:0] id_alu_ctrl,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic              id_is_load,

    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_we,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_we,
    input  logic [DATA_W-1:0] wb_data,

    input  logic              ex_hold,
    input  logic              ex_flush,

    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [CTRL_W-1:0] ex_alu_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_we,
    output logic              ex_is_load,
    output logic [CNT_W-1:0]  stall_cnt
);

    // -----------------------------------------------------------------------
    // EX registers
    // -----------------------------------------------------------------------
    logic              valid_q,    valid_d;
    logic              reg_we_q,   reg_we_d;
    logic              is_load_q,  is_load_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic              use_imm_q,  use_imm_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic              load_use;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              cnt_inc;

    // -----------------------------------------------------------------------
    // Load-use hazard: the instruction in EX is a load whose result is not
    // available until WB, so a dependent instruction in ID must wait a cycle.
    // Writes to r0 are discarded, so a load to r0 never creates a hazard.
    // -----------------------------------------------------------------------
    assign rs1_hit  = id_rs1_use && (id_rs1 == rd_q);
    assign rs2_hit  = id_rs2_use && (id_rs2 == rd_q);
    assign load_use = valid_q && is_load_q && id_valid &&
                      (rd_q != '0) && (rs1_hit || rs2_hit);

    assign id_stall = load_use || ex_hold;

    // Only bubbles that are actually inserted count; a held or flushed cycle
    // does not advance the pipe, so it does not count as a bubble.
    assign cnt_inc  = load_use && !ex_hold && !ex_flush;

    // -----------------------------------------------------------------------
    // Next-state selection. Flush beats hold so a branch redirect can never
    // leave a wrong-path instruction stranded in EX behind a downstream stall.
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d    = valid_q;
        reg_we_d   = reg_we_q;
        is_load_d  = is_load_q;
        alu_ctrl_d = alu_ctrl_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        use_imm_d  = use_imm_q;

        if (ex_flush) begin
            valid_d   = 1'b0;
            reg_we_d  = 1'b0;
            is_load_d = 1'b0;
        end else if (ex_hold) begin
            // every EX register keeps its value
        end else if (load_use) begin
            // bubble; ID keeps its instruction and reissues it next cycle
            valid_d   = 1'b0;
            reg_we_d  = 1'b0;
            is_load_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            reg_we_d   = id_valid && id_reg_we;
            is_load_d  = id_valid && id_is_load;
            alu_ctrl_d = id_alu_ctrl;
            rd_d       = id_rd;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            use_imm_d  = id_use_imm;
        end
    end

    // Saturating bubble counter: sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            is_load_q  <= 1'b0;
            alu_ctrl_q <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            reg_we_q   <= reg_we_d;
            is_load_q  <= is_load_d;
            alu_ctrl_q <= alu_ctrl_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            use_imm_q  <= use_imm_d;
            cnt_q      <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding network, one identical lane per source operand.
    // r0 always reads as zero. EX/MEM is checked before MEM/WB because it
    // carries the younger write to the same register. A load sitting in MEM
    // never needs to be a source: the load-use bubble guarantees a consumer
    // reaches EX only once the load has moved on to WB.
    // -----------------------------------------------------------------------
    logic [REG_AW-1:0] src_rs   [2];
    logic [DATA_W-1:0] src_data [2];
    logic [DATA_W-1:0] fwd_val  [2];

    assign src_rs[0]   = rs1_q;
    assign src_rs[1]   = rs2_q;
    assign src_data[0] = rs1_data_q;
    assign src_data[1] = rs2_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_match;
            logic wb_match;

            assign mem_match = mem_reg_we && (mem_rd == src_rs[gi]);
            assign wb_match  = wb_reg_we  && (wb_rd  == src_rs[gi]);

            assign fwd_val[gi] = (src_rs[gi] == '0) ? '0         :
                                 mem_match          ? mem_result :
                                 wb_match           ? wb_data    :
                                                      src_data[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ex_valid      = valid_q;
    assign ex_a          = fwd_val[0];
    assign ex_store_data = fwd_val[1];
    assign ex_b          = use_imm_q ? imm_q : fwd_val[1];
    assign ex_alu_ctrl   = alu_ctrl_q;
    assign ex_rd         = rd_q;
    assign ex_reg_we     = reg_we_q;
    assign ex_is_load    = is_load_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Directed bench for ex_operand_stage. Each driven cycle pushes the expected
// EX-stage response for that cycle into a queue; an independent monitor pops
// and compares at the falling edge. A second instance with a 5-bit counter
// shares all inputs so counter saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_rs1_use, id_rs2_use, id_use_imm, id_reg_we, id_is_load;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [CW-1:0] id_alu_ctrl;
    logic [AW-1:0] mem_rd, wb_rd;
    logic          mem_reg_we, wb_reg_we;
    logic [DW-1:0] mem_result, wb_data;
    logic          ex_hold, ex_flush;

    logic          id_stall, ex_valid, ex_reg_we, ex_is_load;
    logic [DW-1:0] ex_a, ex_b, ex_store_data;
    logic [CW-1:0] ex_alu_ctrl;
    logic [AW-1:0] ex_rd;
    logic [15:0]   stall_cnt;

    logic          s_id_stall, s_ex_valid, s_ex_reg_we, s_ex_is_load;
    logic [DW-1:0] s_ex_a, s_ex_b, s_ex_store_data;
    logic [CW-1:0] s_ex_alu_ctrl;
    logic [AW-1:0] s_ex_rd;
    logic [4:0]    s_stall_cnt;

    always #5 clk = ~clk;

    ex_operand_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
        .ex_hold(ex_hold), .ex_flush(ex_flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
    );

    ex_operand_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(5)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
        .ex_hold(ex_hold), .ex_flush(ex_flush),
        .id_stall(s_id_stall), .ex_valid(s_ex_valid), .ex_a(s_ex_a), .ex_b(s_ex_b),
        .ex_store_data(s_ex_store_data), .ex_alu_ctrl(s_ex_alu_ctrl), .ex_rd(s_ex_rd),
        .ex_reg_we(s_ex_reg_we), .ex_is_load(s_ex_is_load), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] a, b, sd;
        logic [CW-1:0] ctrl;
        logic [AW-1:0] rd;
        logic          we, ld, stall;
        logic [15:0]   cnt;
        logic [4:0]    cnt_sat;
    } exp_t;

    exp_t q[$];
    int   n_asrt = 0;
    int   n_fail = 0;
    int   n_txn  = 0;
    logic mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v,
                          input logic [AW-1:0] rs1, input logic u1, input logic [DW-1:0] d1,
                          input logic [AW-1:0] rs2, input logic u2, input logic [DW-1:0] d2,
                          input logic [DW-1:0] imm, input logic ui, input logic [CW-1:0] ctrl,
                          input logic [AW-1:0] rd, input logic we, input logic ld);
        id_valid = v;   id_rs1 = rs1; id_rs1_use = u1; id_rs1_data = d1;
        id_rs2 = rs2;   id_rs2_use = u2; id_rs2_data = d2;
        id_imm = imm;   id_use_imm = ui; id_alu_ctrl = ctrl;
        id_rd = rd;     id_reg_we = we;  id_is_load = ld;
    endtask

    task automatic set_fw(input logic [AW-1:0] mrd, input logic mwe, input logic [DW-1:0] mres,
                          input logic [AW-1:0] wrd, input logic wwe, input logic [DW-1:0] wdat);
        mem_rd = mrd; mem_reg_we = mwe; mem_result = mres;
        wb_rd  = wrd; wb_reg_we  = wwe; wb_data    = wdat;
    endtask

    function automatic logic [4:0] sat5(input logic [15:0] c);
        return (c > 16'd31) ? 5'd31 : c[4:0];
    endfunction

    task automatic exp_v(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] sd,
                         input logic [CW-1:0] ctrl, input logic [AW-1:0] rd,
                         input logic we, input logic ld, input logic stall, input logic [15:0] cnt);
        exp_t e;
        e.v = 1'b1; e.a = a; e.b = b; e.sd = sd; e.ctrl = ctrl; e.rd = rd;
        e.we = we; e.ld = ld; e.stall = stall; e.cnt = cnt; e.cnt_sat = sat5(cnt);
        q.push_back(e);
    endtask

    task automatic exp_n(input logic stall, input logic [15:0] cnt);
        exp_t e;
        e.v = 1'b0; e.a = '0; e.b = '0; e.sd = '0; e.ctrl = '0; e.rd = '0;
        e.we = 1'b0; e.ld = 1'b0; e.stall = stall; e.cnt = cnt; e.cnt_sat = sat5(cnt);
        q.push_back(e);
    endtask

    // Monitor: one transaction per falling edge while expectations are queued.
    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                n_txn++;
                $display("txn %0d: v=%0b a=%h b=%h sd=%h ctrl=%h rd=%0d we=%0b ld=%0b stall=%0b cnt=%0d sat=%0d",
                         n_txn, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_ctrl, ex_rd,
                         ex_reg_we, ex_is_load, id_stall, stall_cnt, s_stall_cnt);
                check("ex_valid", ex_valid, e.v);
                check("id_stall", id_stall, e.stall);
                check("stall_cnt", stall_cnt, e.cnt);
                check("sat_stall_cnt", s_stall_cnt, e.cnt_sat);
                check("sat_ex_valid", s_ex_valid, e.v);
                check("ex_reg_we", ex_reg_we, e.we);
                check("ex_is_load", ex_is_load, e.ld);
                if (e.v) begin
                    check("ex_a", ex_a, e.a);
                    check("ex_b", ex_b, e.b);
                    check("ex_store_data", ex_store_data, e.sd);
                    check("ex_alu_ctrl", ex_alu_ctrl, e.ctrl);
                    check("ex_rd", ex_rd, e.rd);
                end
            end else if (ex_valid) begin
                check("unexpected_valid", ex_valid, 1'b0);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        ex_hold = 1'b0;
        ex_flush = 1'b0;
        set_id(0, 0,0,16'h0, 0,0,16'h0, 16'h0,0, 4'd0, 0,0,0);
        set_fw(0,0,16'h0, 0,0,16'h0);

        // Power-up reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_ex_reg_we", ex_reg_we, 1'b0);
        check("rst_ex_is_load", ex_is_load, 1'b0);
        check("rst_stall_cnt", stall_cnt, 16'h0);
        check("rst_ex_alu_ctrl", ex_alu_ctrl, 4'h0);
        check("rst_ex_rd", ex_rd, 3'd0);
        check("rst_ex_a", ex_a, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_on = 1'b1;

        // C0: producer add r1 = r0 + 5
        set_id(1, 0,0,16'h0, 0,0,16'h0, 16'h0005,1, 4'd2, 3'd1,1,0);
        exp_n(0, 16'd0);
        // C1: consumer add r2, r1, r1 enters ID
        tick();
        set_id(1, 1,1,16'h0000, 1,1,16'h0000, 16'h0,0, 4'd0, 3'd2,1,0);
        exp_v(16'h0000, 16'h0005, 16'h0000, 4'd2, 3'd1, 1, 0, 0, 16'd0);
        // C2: r1 in MEM with 0x1234 -> both operands forwarded
        tick();
        set_fw(3'd1,1,16'h1234, 0,0,16'h0);
        set_id(1, 3,1,16'h1111, 3,1,16'h1111, 16'h0007,1, 4'd5, 3'd5,1,0);
        exp_v(16'h1234, 16'h1234, 16'h1234, 4'd0, 3'd2, 1, 0, 0, 16'd0);
        // C3: MEM and WB both write r3 -> MEM wins
        tick();
        set_fw(3'd3,1,16'h00AA, 3'd3,1,16'h0055);
        set_id(1, 6,1,16'h0100, 0,0,16'h0, 16'h0002,1, 4'd0, 3'd4,1,1);
        exp_v(16'h00AA, 16'h0007, 16'h00AA, 4'd5, 3'd5, 1, 0, 0, 16'd0);
        // C4: load r4 in EX (rs1=r6 forwarded from WB, MEM disabled); ID reads r4
        tick();
        set_fw(3'd6,0,16'hDEAD, 3'd6,1,16'h0200);
        set_id(1, 4,1,16'h0000, 2,1,16'h0022, 16'h0,0, 4'd3, 3'd7,1,0);
        exp_v(16'h0200, 16'h0002, 16'h0000, 4'd0, 3'd4, 1, 1, 1, 16'd0);
        // C5: bubble, load now in MEM
        tick();
        set_fw(3'd4,1,16'hBEEF, 0,0,16'h0);
        exp_n(0, 16'd1);
        // C6: consumer in EX, load result from WB
        tick();
        set_fw(0,0,16'h0, 3'd4,1,16'h4444);
        set_id(1, 5,1,16'h0A0A, 6,1,16'h0B0B, 16'h0,0, 4'd9, 3'd3,1,0);
        exp_v(16'h4444, 16'h0022, 16'h0022, 4'd3, 3'd7, 1, 0, 0, 16'd1);
        // C7..C9: hold for three cycles, EX frozen
        tick();
        set_fw(0,0,16'h0, 0,0,16'h0);
        ex_hold = 1'b1;
        set_id(1, 1,1,16'h1111, 1,1,16'h1111, 16'h0,0, 4'd1, 3'd1,1,0);
        exp_v(16'h0A0A, 16'h0B0B, 16'h0B0B, 4'd9, 3'd3, 1, 0, 1, 16'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_v(16'h0A0A, 16'h0B0B, 16'h0B0B, 4'd9, 3'd3, 1, 0, 1, 16'd1);
        end
        // C10: hold released, contents still the held instruction
        tick();
        ex_hold = 1'b0;
        exp_v(16'h0A0A, 16'h0B0B, 16'h0B0B, 4'd9, 3'd3, 1, 0, 0, 16'd1);
        // C11: hold and flush together
        tick();
        ex_hold = 1'b1;
        ex_flush = 1'b1;
        set_id(1, 2,1,16'h2222, 2,1,16'h2222, 16'h0,0, 4'd7, 3'd2,1,0);
        exp_v(16'h1111, 16'h1111, 16'h1111, 4'd1, 3'd1, 1, 0, 1, 16'd1);
        // C12: flushed -> bubble; r0 consumer enters ID
        tick();
        ex_hold = 1'b0;
        ex_flush = 1'b0;
        set_id(1, 0,1,16'h5555, 0,1,16'h5555, 16'h0,0, 4'd4, 3'd6,1,0);
        exp_n(0, 16'd1);
        // C13: writes to r0 in flight must not be forwarded
        tick();
        set_fw(3'd0,1,16'hFFFF, 3'd0,1,16'hFFFF);
        set_id(0, 0,0,16'h0, 0,0,16'h0, 16'h0,0, 4'd0, 0,0,0);
        exp_v(16'h0000, 16'h0000, 16'h0000, 4'd4, 3'd6, 1, 0, 0, 16'd1);

        // Repeated load r4 / rs2-consumer pairs, one bubble per pair
        for (int i = 0; i < 40; i++) begin
            tick();
            set_fw(0,0,16'h0, 0,0,16'h0);
            set_id(1, 0,0,16'h0, 0,0,16'h0, 16'h0004,1, 4'd0, 3'd4,1,1);
            exp_n(0, 16'(1 + i));
            tick();
            set_id(1, 0,0,16'h0, 4,1,16'h0000, 16'h0,0, 4'd6, 3'd5,1,0);
            exp_v(16'h0000, 16'h0004, 16'h0000, 4'd0, 3'd4, 1, 1, 1, 16'(1 + i));
        end

        // Load to r0 followed by a reader of r0: no hazard
        tick();
        set_id(1, 0,0,16'h0, 0,0,16'h0, 16'h0,1, 4'd0, 3'd0,1,1);
        exp_n(0, 16'd41);
        tick();
        set_id(1, 0,1,16'h7777, 0,1,16'h7777, 16'h0,0, 4'd0, 3'd1,1,0);
        exp_v(16'h0000, 16'h0000, 16'h0000, 4'd0, 3'd0, 1, 1, 0, 16'd41);
        tick();
        set_id(0, 0,0,16'h0, 0,0,16'h0, 16'h0,0, 4'd0, 0,0,0);
        exp_v(16'h0000, 16'h0000, 16'h0000, 4'd0, 3'd1, 1, 0, 0, 16'd41);

        // Mid-stream asynchronous reset, checked away from any clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ex_valid", ex_valid, 1'b0);
        check("async_rst_ex_reg_we", ex_reg_we, 1'b0);
        check("async_rst_ex_is_load", ex_is_load, 1'b0);
        check("async_rst_stall_cnt", stall_cnt, 16'h0);
        check("async_rst_sat_cnt", s_stall_cnt, 5'h0);
        tick();
        check("rst_held_ex_valid", ex_valid, 1'b0);
        check("rst_held_stall_cnt", stall_cnt, 16'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
